vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with an integrated colour quantiser. It is the successor to the fixed 800x600 tester: every H/V interval, sync polarity, pixel-clock divide and DAC colour depth is a parameter.
- It derives a pixel-tick enable from the system clock and runs horizontal/vertical counters.
- It emits sync, data-enable and frame/line markers.
- It samples 24-bit RGB from a pattern source and drives pipeline-aligned COLOR_BITS-per-channel DAC outputs.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, hsync pulse width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync asserted level (1 = active-high)
VS_POL, 1, vsync asserted level
CLK_DIV, 2, system clocks per pixel tick (>=1)
COLOR_BITS, 2, DAC bits per channel (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes counters and blanks outputs
rgb_in  in  24  {R,G,B} 8 bits each, for pixel at (h_count,v_count), valid same cycle
h_count  out  clog2(H_TOTAL)  current pixel column
v_count  out  clog2(V_TOTAL)  current line
pix_tick  out  1  one-clk pulse, pixel advance
line_start  out  1  pix_tick with h_count==0
frame_start  out  1  pix_tick with h_count==0 and v_count==0
h_sync  out  1  registered, pipeline-aligned hsync
v_sync  out  1  registered, pipeline-aligned vsync
de  out  1  registered, aligned data-enable
red_port / green_port / blue_port  out  COLOR_BITS each  quantised colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 1040 x 666.
- Reset (async assert, sync release) values:
  - counters, divider, pix_tick, line_start, frame_start, de and all colour ports are 0.
  - h_sync = ~HS_POL; v_sync = ~VS_POL.
- Divider:
  - counts 0..CLK_DIV-1 while en=1; pix_tick=1 in the clk where divider==CLK_DIV-1.
  - CLK_DIV=1 gives pix_tick every enabled clk.
- Counters advance only on pix_tick.
  - h_count wraps H_TOTAL-1 -> 0 and increments v_count.
  - v_count wraps V_TOTAL-1 -> 0 in the same tick that h_count wraps.
- Decode, combinational on the counters:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs_raw asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line, aligned to h=0.
- Pipeline: one register stage, loaded on pix_tick.
  - h_sync, v_sync, de and the colour ports all reflect the counter values of the previous pixel tick.
  - Fixed latency is 1 pixel tick (CLK_DIV clks); sync and colour always stay mutually aligned.
- Quantiser, per channel:
  - q = min((c + 2^(7-COLOR_BITS)) >> (8-COLOR_BITS), 2^COLOR_BITS-1), using 9-bit intermediate, round-to-nearest with saturation.
  - COLOR_BITS=8 passes c through unchanged.
  - If active=0, colour registers load 0 (blanking) regardless of rgb_in.
- en=0:
  - divider and counters hold, pix_tick=0.
  - At the next clk, de=0, colours=0 and syncs go deasserted.
  - On en rising, timing resumes from the held position; no frame restart.
- Reset mid-frame: everything returns to reset values immediately. After release, the first pix_tick occurs CLK_DIV clks later with frame_start=1.
- Parameter legality (elaboration check): all intervals >=1, CLK_DIV>=1, 1<=COLOR_BITS<=8.

Decomposition:
- Shared package vga_pkg:
  - default 800x600@72 timing constants;
  - H_TOTAL/V_TOTAL and counter-width functions (clog2);
  - quantise function.
- One natural sub-module: vga_color_quant, combinational per channel, with parameter COLOR_BITS and an active-blank input. It is instantiated three times; the output registers stay in the top.

Test Plan:
1. Defaults, en=1, run 2 frames -> line period 2080 clks; frame_start every 1,385,280 clks; hsync high for exactly 120 ticks starting 1 tick after h_count==856; vsync high for 6 lines starting 1 tick after v_count==637.
2. Quantiser COLOR_BITS=2, rgb_in={8'h1F,8'h60,8'hFF} during active -> ports 0,2,3 one tick later. Same data with h_count=800 -> all 0.
3. Small mode: H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HS_POL=VS_POL=0 -> h wraps 7->0, v wraps 5->0 simultaneously, and sync is low exactly in its window.
4. Deassert en for 37 clks mid-line at h=300 -> counters hold at 300; de/colours 0; syncs idle. Resume continues at 301 with no extra frame_start.
5. Assert rst_n=0 asynchronously mid-vsync (v=639) -> v_sync=~VS_POL and counters 0 with no clk edge. After release, frame_start on first pix_tick.
6. COLOR_BITS=8, random rgb_in -> colour ports equal rgb_in delayed 1 tick inside active, 0 outside.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and helpers for the VGA raster generator.
// Defaults describe 800x600@72 with a 2:1 pixel-clock divide and 2-bit DACs.
package vga_pkg;

  localparam int DEF_H_ACTIVE   = 800;
  localparam int DEF_H_FP       = 56;
  localparam int DEF_H_SYNC     = 120;
  localparam int DEF_H_BP       = 64;
  localparam int DEF_V_ACTIVE   = 600;
  localparam int DEF_V_FP       = 37;
  localparam int DEF_V_SYNC     = 6;
  localparam int DEF_V_BP       = 23;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_COLOR_BITS = 2;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-to-nearest with saturation; the result sits in the low 'bits' bits.
  function automatic logic [7:0] quantise(input logic [7:0] c, input int bits);
    logic [8:0] sum;
    logic [8:0] q;
    logic [8:0] lim;
    if (bits >= 8) return c;
    sum = {1'b0, c} + (9'd1 << (7 - bits));
    q   = sum >> (8 - bits);
    lim = (9'd1 << bits) - 9'd1;
    return 8'((q > lim) ? lim : q);
  endfunction

endpackage

// File: rtl/vga_color_quant.sv
// Single-channel colour quantiser: 8-bit in, COLOR_BITS out, forced to 0 when
// the raster is outside the visible area.
module vga_color_quant
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic [7:0]            c,
  input  logic                  active,
  output logic [COLOR_BITS-1:0] q
);

  assign q = active ? COLOR_BITS'(quantise(c, COLOR_BITS)) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a one-tick output pipeline
// that keeps sync, data-enable and quantised colour mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  localparam int H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW        = cnt_width(H_TOTAL),
  localparam int VW        = cnt_width(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [23:0]           rgb_in,
  output logic [HW-1:0]         h_count,
  output logic [VW-1:0]         v_count,
  output logic                  pix_tick,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] red_port,
  output logic [COLOR_BITS-1:0] green_port,
  output logic [COLOR_BITS-1:0] blue_port
);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_bad_params
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  localparam int                DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q;
  logic          tick_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      tick_q <= (div_q == DIV_LAST);
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  // Gating with en lets a pending tick survive a pause and fire on resume.
  assign pix_tick = tick_q & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_tick) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
      end else begin
        h_count <= h_count + HW'(1);
      end
    end
  end

  assign line_start  = pix_tick & (h_count == '0);
  assign frame_start = line_start & (v_count == '0);

  logic active;
  logic hs_raw;
  logic vs_raw;

  assign active = (h_count < H_VIS) && (v_count < V_VIS);
  assign hs_raw = (h_count >= HS_START) && (h_count < HS_END);
  assign vs_raw = (v_count >= VS_START) && (v_count < VS_END);

  logic [COLOR_BITS-1:0] q_r;
  logic [COLOR_BITS-1:0] q_g;
  logic [COLOR_BITS-1:0] q_b;

  vga_color_quant #(.COLOR_BITS(COLOR_BITS)) u_quant_r (
    .c(rgb_in[23:16]), .active(active), .q(q_r)
  );
  vga_color_quant #(.COLOR_BITS(COLOR_BITS)) u_quant_g (
    .c(rgb_in[15:8]), .active(active), .q(q_g)
  );
  vga_color_quant #(.COLOR_BITS(COLOR_BITS)) u_quant_b (
    .c(rgb_in[7:0]), .active(active), .q(q_b)
  );

  // One stage, loaded per pixel tick, so sync and colour share the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync     <= ~HS_POL;
      v_sync     <= ~VS_POL;
      de         <= 1'b0;
      red_port   <= '0;
      green_port <= '0;
      blue_port  <= '0;
    end else if (!en) begin
      h_sync     <= ~HS_POL;
      v_sync     <= ~VS_POL;
      de         <= 1'b0;
      red_port   <= '0;
      green_port <= '0;
      blue_port  <= '0;
    end else if (pix_tick) begin
      h_sync     <= hs_raw ? HS_POL : ~HS_POL;
      v_sync     <= vs_raw ? VS_POL : ~VS_POL;
      de         <= active;
      red_port   <= q_r;
      green_port <= q_g;
      blue_port  <= q_b;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance for divider, hsync, quantiser and
// pause behaviour; a tiny 8x6 instance for frame wrap, vsync and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default-parameter instance.
  logic        rst_n0, en0;
  logic [23:0] rgb0;
  logic [10:0] h0;
  logic [9:0]  v0;
  logic        pix_tick0, line_start0, frame_start0, hs0, vs0, de0;
  logic [1:0]  r0, g0, b0;

  vga_timing_gen u_d0 (
    .clk(clk), .rst_n(rst_n0), .en(en0), .rgb_in(rgb0),
    .h_count(h0), .v_count(v0), .pix_tick(pix_tick0),
    .line_start(line_start0), .frame_start(frame_start0),
    .h_sync(hs0), .v_sync(vs0), .de(de0),
    .red_port(r0), .green_port(g0), .blue_port(b0)
  );

  // Small mode: 8 x 6 total, active-low syncs, CLK_DIV=1, 8-bit pass-through colour.
  logic        rst_n1, en1;
  logic [23:0] rgb1;
  logic [2:0]  h1, v1;
  logic        pix_tick1, line_start1, frame_start1, hs1, vs1, de1;
  logic [7:0]  r1, g1, b1;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_BITS(8)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n1), .en(en1), .rgb_in(rgb1),
    .h_count(h1), .v_count(v1), .pix_tick(pix_tick1),
    .line_start(line_start1), .frame_start(frame_start1),
    .h_sync(hs1), .v_sync(vs1), .de(de1),
    .red_port(r1), .green_port(g1), .blue_port(b1)
  );

  int fs0_cnt = 0;
  always @(negedge clk) if (frame_start0) fs0_cnt++;

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
  } qvec_t;

  qvec_t qtab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge carrying a pix_tick on u_d0 (any column when target < 0).
  task automatic wait_h0(input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pix_tick0 && (target < 0 || int'(h0) == target)) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for h_count=%0d, got %0d", name, target, h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, h0=%0d h1=%0d", h0, h1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, c, hs_first, hs_cnt, de_cnt, hold_bad, fs_snap;
    bit done, found;
    logic [23:0] rgb_last;

    qtab[0] = '{24'h1F60FF, 2'd0, 2'd2, 2'd3};
    qtab[1] = '{24'h000000, 2'd0, 2'd0, 2'd0};
    qtab[2] = '{24'h205FE0, 2'd1, 2'd1, 2'd3};
    qtab[3] = '{24'h9FA0DF, 2'd2, 2'd3, 2'd3};
    qtab[4] = '{24'h3F7FBF, 2'd1, 2'd2, 2'd3};
    qtab[5] = '{24'hDF1F20, 2'd3, 2'd0, 2'd1};
    qtab[6] = '{24'hFFFFFF, 2'd3, 2'd3, 2'd3};
    qtab[7] = '{24'h607F80, 2'd2, 2'd2, 2'd2};

    rst_n0 = 1'b0; en0 = 1'b1; rgb0 = '0;
    rst_n1 = 1'b0; en1 = 1'b1; rgb1 = '0;
    repeat (3) @(negedge clk);

    check("rst_h0", h0, 0);
    check("rst_v0", v0, 0);
    check("rst_tick0", {pix_tick0, line_start0, frame_start0}, 0);
    check("rst_sync0", {hs0, vs0}, 2'b00);
    check("rst_de_col0", {de0, r0, g0, b0}, 0);
    check("rst_sync1", {hs1, vs1}, 2'b11);

    // Divider start-up, line period and hsync/de windows on the default timing.
    rst_n0 = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pix_tick0) begin n = i; break; end
    end
    check("first_tick_clks", n, 2);
    check("first_frame_start", {frame_start0, line_start0}, 2'b11);

    c = 0; hs_first = -1; hs_cnt = 0; de_cnt = 0; done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      c++;
      if (pix_tick0) begin
        if (hs0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(h0);
        end
        if (de0) de_cnt++;
        if (line_start0) done = 1'b1;
      end
    end
    check("line_period_clks", c, 2080);
    check("line1_v", v0, 1);
    check("hsync_first_h", hs_first, 857);
    check("hsync_ticks", hs_cnt, 120);
    check("de_ticks", de_cnt, 800);

    // Quantiser vectors, one per pixel tick on line 1.
    for (int i = 0; i < 8; i++) begin
      rgb0 = qtab[i].rgb;
      @(negedge clk);
      check($sformatf("quant_%0d", i), {r0, g0, b0}, {qtab[i].r, qtab[i].g, qtab[i].b});
      check($sformatf("quant_de_%0d", i), de0, 1'b1);
      wait_h0(-1, 4, "quant_tick");
    end

    // Pause for 37 clks at h=300.
    rgb0 = 24'hFFFFFF;
    wait_h0(299, 1000, "wait_h299");
    @(negedge clk);
    check("pre_pause_h", h0, 300);
    check("pre_pause_out", {de0, r0, g0, b0}, 7'h7F);
    en0 = 1'b0;
    fs_snap = fs0_cnt;
    @(negedge clk);
    check("pause_blank", {de0, r0, g0, b0, hs0, vs0}, 0);
    hold_bad = 0;
    repeat (36) begin
      @(negedge clk);
      if (pix_tick0 || h0 != 11'd300) hold_bad++;
    end
    check("pause_hold_h", h0, 300);
    check("pause_glitches", hold_bad, 0);
    en0 = 1'b1;
    @(negedge clk);
    check("resume_tick", {pix_tick0, h0}, {1'b1, 11'd300});
    @(negedge clk);
    check("resume_h", h0, 301);
    check("resume_out", {de0, r0, g0, b0}, 7'h7F);
    check("resume_no_frame", fs0_cnt, fs_snap);

    // Active-area edge: column 799 visible, 800 blanked with the same data.
    rgb0 = 24'h1F60FF;
    wait_h0(799, 1200, "wait_h799");
    @(negedge clk);
    check("col799", {de0, r0, g0, b0}, {1'b1, 2'd0, 2'd2, 2'd3});
    wait_h0(800, 4, "wait_h800");
    @(negedge clk);
    check("col800_blank", {de0, r0, g0, b0}, 0);

    // Small mode: two full frames against an index-derived model.
    rst_n1 = 1'b1;
    rgb_last = '0;
    for (int t = 0; t < 96; t++) begin
      int ph, pv;
      logic hs_e, vs_e, de_e;
      logic [23:0] col_e;
      @(negedge clk);
      check("s_tick", pix_tick1, 1'b1);
      check("s_h", h1, t % 8);
      check("s_v", v1, (t / 8) % 6);
      check("s_line_start", line_start1, (t % 8) == 0);
      check("s_frame_start", frame_start1, (t % 48) == 0);
      if (t == 0) begin
        hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0;
      end else begin
        ph = (t - 1) % 8;
        pv = ((t - 1) / 8) % 6;
        hs_e = !(ph == 5 || ph == 6);
        vs_e = !(pv == 4);
        de_e = (ph < 4) && (pv < 3);
      end
      col_e = de_e ? rgb_last : 24'h0;
      check("s_sync", {hs1, vs1}, {hs_e, vs_e});
      check("s_de", de1, de_e);
      check("s_colour", {r1, g1, b1}, col_e);
      rgb1 = 24'($urandom());
      rgb_last = rgb1;
    end

    // Asynchronous reset in the middle of the vsync line.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (h1 == 3'd2 && v1 == 3'd4) begin found = 1'b1; break; end
    end
    check("reach_vsync_line", found, 1'b1);
    check("vsync_asserted", vs1, 1'b0);
    #2 rst_n1 = 1'b0;
    #1;
    check("async_rst_counters", {h1, v1}, 0);
    check("async_rst_sync", {hs1, vs1}, 2'b11);
    check("async_rst_de", de1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("in_reset_tick", pix_tick1, 1'b0);
    rst_n1 = 1'b1;
    @(negedge clk);
    check("post_rst_frame_start", {pix_tick1, frame_start1}, 2'b11);
    @(negedge clk);
    check("post_rst_h", h1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
